imo_cmd_arbiter: RTL and testbench

IMO_CMD_ARBITER -- requirements
Module: imo_cmd_arbiter

---
 rtl/imo_cmd_arbiter_if.sv | 31 +++
 rtl/imo_cmd_arbiter.sv | 105 ++++++++++
 tb/tb_imo_cmd_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imo_cmd_arbiter_if.sv
// Bundle of the host, IMO and DRAM-scheduler handshake signals around the arbiter.
// The requester/scheduler side uses the master modport and the arbiter uses the slave modport.
interface imo_cmd_arbiter_if #(
    parameter int CMD_W  = 8,
    parameter int ADDR_W = 60
);
    logic              host_valid;
    logic [CMD_W-1:0]  host_cmd;
    logic [ADDR_W-1:0] host_addr;
    logic              host_ack;
    logic              imo_valid;
    logic [CMD_W-1:0]  imo_cmd;
    logic [ADDR_W-1:0] imo_addr;
    logic              imo_ack;
    logic              out_valid;
    logic [CMD_W-1:0]  out_cmd;
    logic [ADDR_W-1:0] out_addr;
    logic              out_src;
    logic              out_ack;
    logic              busy;

    modport master (
        output host_valid, host_cmd, host_addr, imo_valid, imo_cmd, imo_addr, out_ack,
        input  host_ack, imo_ack, out_valid, out_cmd, out_addr, out_src, busy
    );

    modport slave (
        input  host_valid, host_cmd, host_addr, imo_valid, imo_cmd, imo_addr, out_ack,
        output host_ack, imo_ack, out_valid, out_cmd, out_addr, out_src, busy
    );
endinterface

// File: rtl/imo_cmd_arbiter.sv
// Two-requester command arbiter: host has priority, while a saturating starvation
// counter forces an IMO grant once the IMO has waited STARVE_LIMIT cycles.
module imo_cmd_arbiter #(
    parameter int CMD_W        = 8,
    parameter int ADDR_W       = 60,
    parameter int STARVE_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    imo_cmd_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [CMD_W-1:0]  out_cmd_q, out_cmd_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_src_q, out_src_d;
    logic [4:0]        starve_cnt_q, starve_cnt_d;
    logic              grant_host;
    logic              grant_imo;
    logic              imo_owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_cmd_q    <= '0;
            out_addr_q   <= '0;
            out_src_q    <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            out_cmd_q    <= out_cmd_d;
            out_addr_q   <= out_addr_d;
            out_src_q    <= out_src_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_cmd_d    = out_cmd_q;
        out_addr_d   = out_addr_q;
        out_src_d    = out_src_q;
        starve_cnt_d = starve_cnt_q;
        grant_host   = 1'b0;
        grant_imo    = 1'b0;
        imo_owner    = (state_q != IDLE) && out_src_q;

        case (state_q)
            IDLE: begin
                if (bus.imo_valid && (starve_cnt_q == LIMIT)) begin
                    grant_imo = 1'b1;
                end else if (bus.host_valid) begin
                    grant_host = 1'b1;
                end else if (bus.imo_valid) begin
                    grant_imo = 1'b1;
                end
                if (grant_host) begin
                    out_cmd_d  = bus.host_cmd;
                    out_addr_d = bus.host_addr;
                    out_src_d  = 1'b0;
                    state_d    = GRANT;
                end else if (grant_imo) begin
                    out_cmd_d  = bus.imo_cmd;
                    out_addr_d = bus.imo_addr;
                    out_src_d  = 1'b1;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // Requester valid is deliberately not looked at here: once granted, a command completes.
                if (bus.out_ack) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The counter only measures waiting while someone else owns (or could win) the bus.
        if (grant_imo || !bus.imo_valid) begin
            starve_cnt_d = '0;
        end else if (!imo_owner && (starve_cnt_q < LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 5'd1;
        end
    end

    assign bus.out_valid = (state_q == GRANT);
    assign bus.out_cmd   = out_cmd_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_src   = out_src_q;
    assign bus.host_ack  = (state_q == ACK) && !out_src_q;
    assign bus.imo_ack   = (state_q == ACK) && out_src_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_imo_cmd_arbiter.sv
// Scoreboard bench for imo_cmd_arbiter: directed requests push expected grants, a monitor
// checks every grant and ack, and an auto-responder acks the scheduler side after a set delay.
module tb_imo_cmd_arbiter;
    localparam int CMD_W  = 8;
    localparam int ADDR_W = 60;

    typedef struct {
        logic              src;
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    exp_t exp_q[$];
    exp_t cur;
    bit   pending;
    bit   prev_valid;
    int   grant_cyc, imo_grant_cyc, host_ack_cyc, valid_len;
    int   n_host_ack, n_imo_ack;

    bit   ack_en;
    int   ack_dly;
    int   rcnt;
    bit   host_hold;

    imo_cmd_arbiter_if #(.CMD_W(CMD_W), .ADDR_W(ADDR_W)) bus ();

    imo_cmd_arbiter #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input logic src, input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr);
        exp_t e;
        e.src  = src;
        e.cmd  = cmd;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !pending && !bus.busy && !bus.host_valid && !bus.imo_valid;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
    endtask

    // Monitor: one line per completed transaction, checks against the scoreboard.
    initial begin
        pending = 1'b0; prev_valid = 1'b0;
        n_host_ack = 0; n_imo_ack = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending    = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (bus.out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", 64'd1, 64'd0);
                    end else begin
                        cur       = exp_q.pop_front();
                        pending   = 1'b1;
                        grant_cyc = cyc;
                        valid_len = 0;
                        if (cur.src) imo_grant_cyc = cyc;
                    end
                end
                if (bus.out_valid && pending) begin
                    valid_len++;
                    chk("out_src", 64'(bus.out_src), 64'(cur.src));
                    chk("out_cmd", 64'(bus.out_cmd), 64'(cur.cmd));
                    chk("out_addr", 64'(bus.out_addr), 64'(cur.addr));
                end
                if (bus.host_ack || bus.imo_ack) begin
                    chk("ack_exclusive", 64'(bus.host_ack & bus.imo_ack), 64'd0);
                    if (!pending) begin
                        chk("unexpected_ack", 64'd1, 64'd0);
                    end else begin
                        chk("ack_owner", 64'(bus.imo_ack), 64'(cur.src));
                        $display("txn src=%0d cmd=0x%0h addr=0x%0h grant@%0d ack@%0d valid_cycles=%0d",
                                 cur.src, cur.cmd, cur.addr, grant_cyc, cyc, valid_len);
                        pending = 1'b0;
                    end
                    if (bus.host_ack) begin
                        n_host_ack++;
                        host_ack_cyc = cyc;
                    end
                    if (bus.imo_ack) n_imo_ack++;
                end
                prev_valid = bus.out_valid;
            end
        end
    end

    // Scheduler responder: acks each grant after ack_dly extra valid cycles.
    initial begin
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (ack_en) begin
                if (bus.out_valid && !bus.out_ack) begin
                    if (rcnt >= ack_dly) begin
                        bus.out_ack = 1'b1;
                        rcnt = 0;
                    end else begin
                        rcnt++;
                    end
                end else begin
                    bus.out_ack = 1'b0;
                    if (!bus.out_valid) rcnt = 0;
                end
            end
        end
    end

    // Requester agent: drops valid after its ack unless the host is told to keep requesting.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.host_ack && !host_hold) bus.host_valid = 1'b0;
            if (bus.imo_ack) bus.imo_valid = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c0, nh, ni;
        bit seen;
        cyc = 0; checks = 0; errors = 0;
        ack_en = 1'b1; ack_dly = 0; host_hold = 1'b0;
        rst = 1'b1;
        bus.host_valid = 1'b0; bus.host_cmd = '0; bus.host_addr = '0;
        bus.imo_valid  = 1'b0; bus.imo_cmd  = '0; bus.imo_addr  = '0;
        bus.out_ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_host_ack", 64'(bus.host_ack), 64'd0);
        chk("rst_imo_ack", 64'(bus.imo_ack), 64'd0);
        chk("rst_out_cmd", 64'(bus.out_cmd), 64'd0);
        chk("rst_out_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_out_src", 64'(bus.out_src), 64'd0);
        chk("rst_starve", 64'(dut.starve_cnt_q), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Host only, ack on the third valid cycle.
        ack_dly = 2;
        nh = n_host_ack;
        c0 = cyc;
        push(1'b0, 8'h01, 60'h100);
        bus.host_cmd = 8'h01; bus.host_addr = 60'h100; bus.host_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("host_grant_cycle", 64'(grant_cyc - c0), 64'd1);
        chk("host_valid_len", 64'(valid_len), 64'd3);
        chk("host_ack_cycle", 64'(host_ack_cyc - c0), 64'd4);
        chk("host_ack_count", 64'(n_host_ack - nh), 64'd1);
        chk("busy_low_c5", 64'(bus.busy), 64'd0);
        wait_idle("host_only", 20);

        // Simultaneous requests: host first, IMO on the IDLE cycle right after host_ack.
        ack_dly = 0;
        c0 = cyc;
        push(1'b0, 8'h01, 60'h200);
        push(1'b1, 8'h02, 60'h300);
        bus.host_cmd = 8'h01; bus.host_addr = 60'h200; bus.host_valid = 1'b1;
        bus.imo_cmd  = 8'h02; bus.imo_addr  = 60'h300; bus.imo_valid  = 1'b1;
        wait_idle("simul", 30);
        chk("simul_host_ack_cycle", 64'(host_ack_cyc - c0), 64'd2);
        chk("simul_imo_grant_cycle", 64'(imo_grant_cyc - c0), 64'd4);

        // Starvation: host keeps requesting, IMO forced in once the counter hits 16.
        ack_dly = 1;
        host_hold = 1'b1;
        nh = n_host_ack;
        c0 = cyc;
        for (int i = 0; i < 4; i++) push(1'b0, 8'h01, 60'h400);
        push(1'b1, 8'h08, 60'h500);
        push(1'b0, 8'h01, 60'h400);
        bus.host_cmd = 8'h01; bus.host_addr = 60'h400; bus.host_valid = 1'b1;
        bus.imo_cmd  = 8'h08; bus.imo_addr  = 60'h500; bus.imo_valid  = 1'b1;
        repeat (16) @(negedge clk);
        chk("starve_at_limit", 64'(dut.starve_cnt_q), 64'd16);
        chk("starve_idle_cycle", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("starve_imo_granted", 64'(bus.out_valid & bus.out_src), 64'd1);
        chk("starve_cleared", 64'(dut.starve_cnt_q), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.imo_ack;
        end
        chk("starve_imo_ack_seen", 64'(seen), 64'd1);
        host_hold = 1'b0;
        wait_idle("starve", 40);
        chk("starve_host_acks", 64'(n_host_ack - nh), 64'd5);

        // COPY with a long-withheld out_ack: monitor checks stability every valid cycle.
        ack_dly = 10;
        ni = n_imo_ack;
        push(1'b1, 8'h04, {30'h5, 30'h9});
        bus.imo_cmd = 8'h04; bus.imo_addr = {30'h5, 30'h9}; bus.imo_valid = 1'b1;
        wait_idle("copy", 40);
        chk("copy_valid_len", 64'(valid_len), 64'd11);
        chk("copy_imo_acks", 64'(n_imo_ack - ni), 64'd1);

        // Reset in the middle of a grant: command dropped, no ack.
        ack_en = 1'b0;
        bus.out_ack = 1'b0;
        nh = n_host_ack;
        push(1'b0, 8'h10, 60'hABC);
        bus.host_cmd = 8'h10; bus.host_addr = 60'hABC; bus.host_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        bus.host_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_no_ack", 64'(n_host_ack - nh), 64'd0);
        ack_en = 1'b1;
        ack_dly = 0;
        push(1'b1, 8'h02, 60'h777);
        bus.imo_cmd = 8'h02; bus.imo_addr = 60'h777; bus.imo_valid = 1'b1;
        wait_idle("post_rst", 20);

        // out_ack while IDLE is ignored and outputs keep the last grant.
        ack_en = 1'b0;
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
        chk("idle_ack_busy", 64'(bus.busy), 64'd0);
        chk("idle_ack_host_ack", 64'(bus.host_ack), 64'd0);
        chk("idle_ack_imo_ack", 64'(bus.imo_ack), 64'd0);
        chk("idle_ack_out_valid", 64'(bus.out_valid), 64'd0);
        chk("retain_out_cmd", 64'(bus.out_cmd), 64'h02);
        chk("retain_out_addr", 64'(bus.out_addr), 64'h777);
        chk("retain_out_src", 64'(bus.out_src), 64'd1);
        @(negedge clk);
        chk("idle_ack_still_idle", 64'(bus.busy), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
